instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/instr_fetch.sv | 131 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: fetch queue sizing, the canonical NOP and
// the fetch-queue payload, plus field helpers used by the decode path.
package riscv_pkg;

  localparam int          FETCH_DEPTH = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;  // addi x0, x0, 0

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Field extraction for the decode stage fed by instr_fetch.
  function automatic logic [6:0] instr_opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [4:0] instr_rd(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [2:0] instr_funct3(input logic [31:0] instr);
    return instr[14:12];
  endfunction

  function automatic logic [4:0] instr_rs1(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] instr_rs2(input logic [31:0] instr);
    return instr[24:20];
  endfunction

  function automatic logic [6:0] instr_funct7(input logic [31:0] instr);
    return instr[31:25];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue between fetch and decode. Power-of-two depth so the
// pointers wrap naturally; flush empties the queue in one cycle. The head
// entry is read straight from the storage array so decode sees it in the
// same cycle it becomes valid.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int  DEPTH = FETCH_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head_entry,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  slot_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign head_entry = slot_q[rd_ptr_q];

  // Pointer and occupancy update; flush wins over any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (rst_n && do_push && !flush) begin
      slot_q[wr_ptr_q] <= push_entry;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end. Issues sequential word fetches to an in-order
// instruction memory, queues returned words with their PCs for decode, and
// handles redirects by flushing the queue and dropping responses that belong
// to requests issued before the redirect.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = FETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
);

  localparam int          CW               = $clog2(DEPTH) + 1;
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  // fetch_pc: address of the next request. rsp_pc: address belonging to the
  // next response that will be kept. Between redirects requests are strictly
  // sequential, so a single head-PC register replaces a PC tag FIFO.
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;
  logic          q_push;
  logic          q_flush;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic [CW:0]   occupancy;
  logic          req_fire;

  // Request gating: queue slots already reserved by held entries plus
  // in-flight requests must leave room for one more response.
  always_comb begin
    occupancy      = {1'b0, q_count} + {1'b0, outst_q};
    imem_req_valid = rst_n && !redirect_valid && !q_full &&
                     (occupancy < (CW + 1)'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
  end

  // Next-state for PCs, outstanding count and drop counter.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    q_push     = 1'b0;
    q_flush    = 1'b0;
    push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;

    if (req_fire && !(imem_rsp_valid && outst_q != '0)) begin
      outst_d = outst_q + 1'b1;
    end else if (!req_fire && imem_rsp_valid && outst_q != '0) begin
      outst_d = outst_q - 1'b1;
    end

    if (redirect_valid) begin
      // No request fires this cycle, so outst_d is exactly the set of
      // responses still to come, all of which are now stale. Any response
      // arriving this cycle is discarded without touching the queue.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rsp_pc_d   = {redirect_pc[31:2], 2'b00};
      drop_d     = outst_d;
      q_flush    = 1'b1;
    end else if (imem_rsp_valid) begin
      if (drop_q != '0) begin
        drop_d = drop_q - 1'b1;
      end else begin
        q_push   = 1'b1;
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC_ALIGNED;
      rsp_pc_q   <= RESET_PC_ALIGNED;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (q_flush),
    .push       (q_push),
    .push_entry (push_entry),
    .pop        (dec_ready),
    .head_entry (head_entry),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty)
  );

  // Decode view of the queue head; an empty queue shows a NOP at the PC
  // that the next kept instruction will carry.
  always_comb begin
    dec_valid = !q_empty;
    dec_instr = q_empty ? NOP_INSTR : head_entry.instr;
    dec_pc    = q_empty ? rsp_pc_q  : head_entry.pc;
  end

endmodule
